pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Generic parametrised pipeline-stage register with valid/ready handshake, branch flush and
//   bubble insertion; replaces the hand-written per-stage registers (if_id, id_ex, ex_mem, ...).
//   Sits between two pipeline stages, carries an opaque payload of DATA_W bits, and presents a
//   NOP payload whenever the stage holds no valid instruction.
// PARAMETERS
//   DATA_W   150  payload width in bits (packed stage struct)
//   NOP_VAL  '0   payload driven on dn_data_out whenever the stage is empty
//   CNT_W    16   width of the bubble performance counter
// PORTS
//   clk_in         in   1       clock, all state on posedge
//   rst_in         in   1       reset, asynchronous, active-high
//   rdy_in         in   1       global enable; 0 = entire block frozen
//   flush_in       in   1       branch/mispredict squash of this stage
//   up_valid_in    in   1       upstream stage has a payload
//   up_ready_out   out  1       this stage accepts the payload this cycle
//   up_data_in     in   DATA_W  upstream payload
//   dn_valid_out   out  1       this stage holds a valid payload
//   dn_ready_in    in   1       downstream consumes payload this cycle
//   dn_data_out    out  DATA_W  payload to downstream (NOP_VAL when empty)
//   bubble_cnt_out out  CNT_W   count of enabled cycles with dn_valid_out=0
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-transfer): dn_valid_out=0, dn_data_out=NOP_VAL,
//     bubble_cnt_out=0, skid entry empty; in-flight payloads are lost.
//   - Transfer up: up_valid_in & up_ready_out & rdy_in at posedge. Transfer dn: dn_valid_out &
//     dn_ready_in & rdy_in. Latency up->dn: 1 cycle.
//   - rdy_in=0: no state changes, up_ready_out=0, outputs hold their values.
//   - Priority at each enabled edge: flush_in > load > drain.
//     flush: all entries invalid, dn_data_out=NOP_VAL; up_ready_out=1 during flush so the
//       squashed upstream payload is accepted and discarded (never retried).
//     load: accepted payload becomes dn_data_out next cycle, dn_valid_out=1.
//     drain: dn transfer with no load -> dn_valid_out=0, dn_data_out=NOP_VAL (bubble).
//     otherwise hold (downstream stall keeps payload stable, valid never drops).
//   - Simultaneous dn transfer and up load: new payload replaces old in one cycle, no bubble.
//   - bubble_cnt_out: +1 per rdy_in=1 cycle with dn_valid_out=0; saturates at all-ones; only
//     reset clears it (flush does not).
// CONFIGURATION
//   PIPE_SKID_BUF_EN defined: two-entry (main + skid) buffer; up_ready_out is a flop output
//     (= skid empty), breaking the combinational ready path. Payload accepted while downstream
//     stalls goes to skid; skid moves to main on next dn transfer; order strictly preserved.
//     Full (both entries valid): up_ready_out=0 except during flush. Flush empties both.
//   Undefined: single entry; up_ready_out = rdy_in & (~dn_valid_out | dn_ready_in | flush_in)
//     combinationally.
// STRUCTURE
//   cpu_pipe_pkg: stage payload structs (id_ex_t: rs1/rs2 values, rd enable, rd addr, inst
//     type, imm, pc, loading flag), NOP constants per stage, default CNT_W.
//   Sub-module pipe_skid_slot (one payload+valid entry with load/clear) instantiated once
//     for main and, under PIPE_SKID_BUF_EN, once for skid.
// TESTING
//   1 Reset mid-stream: rst_in pulse between edges with dn_valid_out=1 -> immediately
//     dn_valid_out=0, dn_data_out=NOP_VAL, bubble_cnt_out=0.
//   2 Streaming: up_valid_in=1 with data 1..8, dn_ready_in=1 -> dn_data_out 1..8 on
//     consecutive cycles, one cycle after acceptance, no bubbles.
//   3 Backpressure: dn_ready_in=0 for 3 cycles holding 0x5 -> 0x5 stable, valid high; single
//     entry accepts nothing; skid build accepts exactly one more (0x6), then up_ready_out=0.
//   4 Flush with up_valid_in=1, data 0xA -> up_ready_out=1, next cycle dn_valid_out=0,
//     dn_data_out=NOP_VAL, 0xA never appears downstream; skid build drops both entries.
//   5 rdy_in=0 for 4 cycles under traffic -> no transfers, outputs and bubble_cnt_out frozen.
//   6 Empty for 2^CNT_W+3 cycles (CNT_W=4) -> bubble_cnt_out saturates at 4'hF.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline payload types, per-stage NOP constants and pipe_stage_reg defaults.
package cpu_pipe_pkg;

   localparam int PIPE_DATA_W_DEF = 150;
   localparam int PIPE_CNT_W_DEF  = 16;

   typedef enum logic [3:0] {
      INST_NOP    = 4'd0,
      INST_ALU    = 4'd1,
      INST_ALUI   = 4'd2,
      INST_LOAD   = 4'd3,
      INST_STORE  = 4'd4,
      INST_BRANCH = 4'd5,
      INST_JAL    = 4'd6,
      INST_JALR   = 4'd7,
      INST_LUI    = 4'd8,
      INST_AUIPC  = 4'd9,
      INST_SYS    = 4'd10
   } inst_type_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_id_t;

   typedef struct packed {
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic        rd_en;
      logic [4:0]  rd_addr;
      inst_type_e  inst_type;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        loading;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] store_val;
      logic        rd_en;
      logic [4:0]  rd_addr;
      logic        mem_rd;
      logic        mem_wr;
      logic [31:0] pc;
   } ex_mem_t;

   // IF/ID bubble carries a canonical addi x0,x0,0 so decode sees a real no-op
   localparam if_id_t IF_ID_NOP = '{pc: 32'h0, inst: 32'h0000_0013};

   localparam id_ex_t ID_EX_NOP = '{
      rs1_val:   32'h0,
      rs2_val:   32'h0,
      rd_en:     1'b0,
      rd_addr:   5'd0,
      inst_type: INST_NOP,
      imm:       32'h0,
      pc:        32'h0,
      loading:   1'b0
   };

   localparam ex_mem_t EX_MEM_NOP = '{
      alu_res:   32'h0,
      store_val: 32'h0,
      rd_en:     1'b0,
      rd_addr:   5'd0,
      mem_rd:    1'b0,
      mem_wr:    1'b0,
      pc:        32'h0
   };

   localparam int IF_ID_W  = $bits(if_id_t);
   localparam int ID_EX_W  = $bits(id_ex_t);
   localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload+valid storage entry; clear wins over load, empty entry holds NOP_VAL.
module pipe_skid_slot
   import cpu_pipe_pkg::*;
#(
   parameter int                DATA_W  = PIPE_DATA_W_DEF,
   parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic              valid,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         valid <= 1'b0;
         q     <= NOP_VAL;
      end else if (clear) begin
         valid <= 1'b0;
         q     <= NOP_VAL;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush and bubble counter.
// Define PIPE_SKID_BUF_EN for a two-entry (main + skid) build with registered up_ready_out.
module pipe_stage_reg
   import cpu_pipe_pkg::*;
#(
   parameter int                DATA_W  = PIPE_DATA_W_DEF,
   parameter logic [DATA_W-1:0] NOP_VAL = '0,
   parameter int                CNT_W   = PIPE_CNT_W_DEF
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              up_valid_in,
   output logic              up_ready_out,
   input  logic [DATA_W-1:0] up_data_in,
   output logic              dn_valid_out,
   input  logic              dn_ready_in,
   output logic [DATA_W-1:0] dn_data_out,
   output logic [CNT_W-1:0]  bubble_cnt_out
);

   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic              main_load;
   logic              main_clear;
   logic [DATA_W-1:0] main_d;
   logic              up_xfer;
   logic              dn_xfer;
   logic [CNT_W-1:0]  bubble_cnt;

   assign up_xfer = up_valid_in & up_ready_out;
   assign dn_xfer = rdy_in & main_valid & dn_ready_in;

`ifdef PIPE_SKID_BUF_EN
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic              skid_load;
   logic              skid_clear;

   // ready only looks at the skid flop, never at dn_ready_in
   assign up_ready_out = rdy_in & (~skid_valid | flush_in);

   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = up_data_in;
      if (rdy_in) begin
         if (flush_in) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
         end else if (skid_valid) begin
            if (dn_xfer) begin
               main_load  = 1'b1;
               main_d     = skid_data;
               skid_clear = 1'b1;
            end
         end else if (up_xfer) begin
            if (!main_valid || dn_xfer)
               main_load = 1'b1;
            else
               skid_load = 1'b1;
         end else if (dn_xfer) begin
            main_clear = 1'b1;
         end
      end
   end

   pipe_skid_slot #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL)
   ) u_skid (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .load   (skid_load),
      .clear  (skid_clear),
      .d      (up_data_in),
      .valid  (skid_valid),
      .q      (skid_data)
   );
`else
   assign up_ready_out = rdy_in & (~main_valid | dn_ready_in | flush_in);

   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_d     = up_data_in;
      if (rdy_in) begin
         if (flush_in)
            main_clear = 1'b1;
         else if (up_xfer)
            main_load = 1'b1;
         else if (dn_xfer)
            main_clear = 1'b1;
      end
   end
`endif

   pipe_skid_slot #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL)
   ) u_main (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .load   (main_load),
      .clear  (main_clear),
      .d      (main_d),
      .valid  (main_valid),
      .q      (main_data)
   );

   // flush does not clear the counter; it tracks lost throughput across squashes too
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         bubble_cnt <= '0;
      else if (rdy_in && !main_valid && (bubble_cnt != '1))
         bubble_cnt <= bubble_cnt + CNT_W'(1);
   end

   assign dn_valid_out   = main_valid;
   assign dn_data_out    = main_data;
   assign bubble_cnt_out = bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (8-bit payload, NOP 0xEE, 4-bit bubble counter).
module tb_pipe_stage_reg;

   localparam int         DW  = 8;
   localparam int         CW  = 4;
   localparam logic [7:0] NOP = 8'hEE;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          rdy_in;
   logic          flush_in;
   logic          up_valid_in;
   logic          up_ready_out;
   logic [DW-1:0] up_data_in;
   logic          dn_valid_out;
   logic          dn_ready_in;
   logic [DW-1:0] dn_data_out;
   logic [CW-1:0] bubble_cnt_out;

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] sb_q[$];
   logic [CW-1:0] exp_cnt = '0;

   pipe_stage_reg #(
      .DATA_W  (DW),
      .NOP_VAL (NOP),
      .CNT_W   (CW)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .flush_in       (flush_in),
      .up_valid_in    (up_valid_in),
      .up_ready_out   (up_ready_out),
      .up_data_in     (up_data_in),
      .dn_valid_out   (dn_valid_out),
      .dn_ready_in    (dn_ready_in),
      .dn_data_out    (dn_data_out),
      .bubble_cnt_out (bubble_cnt_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic f, input logic v,
                      input logic [DW-1:0] d, input logic dr);
      rdy_in      = r;
      flush_in    = f;
      up_valid_in = v;
      up_data_in  = d;
      dn_ready_in = dr;
      @(posedge clk_in);
      #1;
   endtask

   // Monitor: compares outputs against the in-stage queue, then advances the model for the coming edge
   always @(negedge clk_in) begin
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic          e_rdy;
      if (!rst_in) begin
         e_valid = (sb_q.size() != 0);
         e_data  = e_valid ? sb_q[0] : NOP;
`ifdef PIPE_SKID_BUF_EN
         e_rdy   = rdy_in & ((sb_q.size() < 2) | flush_in);
`else
         e_rdy   = rdy_in & (~e_valid | dn_ready_in | flush_in);
`endif
         chk("mon_dn_valid", 32'(dn_valid_out), 32'(e_valid));
         chk("mon_dn_data", 32'(dn_data_out), 32'(e_data));
         chk("mon_up_ready", 32'(up_ready_out), 32'(e_rdy));
         chk("mon_bubble_cnt", 32'(bubble_cnt_out), 32'(exp_cnt));
         if (rdy_in) begin
            if (!e_valid && exp_cnt != 4'hF)
               exp_cnt = exp_cnt + 4'd1;
            if (flush_in) begin
               sb_q.delete();
            end else begin
               if (e_valid && dn_ready_in)
                  void'(sb_q.pop_front());
               if (up_valid_in && e_rdy)
                  sb_q.push_back(up_data_in);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in      = 1'b1;
      rdy_in      = 1'b0;
      flush_in    = 1'b0;
      up_valid_in = 1'b0;
      up_data_in  = '0;
      dn_ready_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("reset_dn_valid", 32'(dn_valid_out), 32'd0);
      chk("reset_dn_data", 32'(dn_data_out), 32'(NOP));
      chk("reset_bubble_cnt", 32'(bubble_cnt_out), 32'd0);
      rst_in = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // streaming 1..8, one cycle latency, no bubbles
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
         chk("stream_valid", 32'(dn_valid_out), 32'd1);
         chk("stream_data", 32'(dn_data_out), 32'(i));
      end
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("stream_drain", 32'(dn_data_out), 32'(NOP));

      // backpressure holding 0x5 while 0x6 is offered
      cyc(1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 8'h06, 1'b0);
         chk("bp_hold_data", 32'(dn_data_out), 32'h05);
         chk("bp_hold_valid", 32'(dn_valid_out), 32'd1);
      end
      chk("bp_up_ready", 32'(up_ready_out), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef PIPE_SKID_BUF_EN
      chk("bp_skid_next", 32'(dn_data_out), 32'h06);
`else
      chk("bp_single_next", 32'(dn_data_out), 32'(NOP));
`endif
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("bp_empty", 32'(dn_valid_out), 32'd0);

      // flush with 0xA offered
      cyc(1'b1, 1'b0, 1'b1, 8'h03, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 8'h04, 1'b0);
      rdy_in = 1'b1; flush_in = 1'b1; up_valid_in = 1'b1; up_data_in = 8'h0A; dn_ready_in = 1'b0;
      #2;
      chk("flush_up_ready", 32'(up_ready_out), 32'd1);
      @(posedge clk_in);
      #1;
      chk("flush_dn_valid", 32'(dn_valid_out), 32'd0);
      chk("flush_dn_data", 32'(dn_data_out), 32'(NOP));
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("flush_after", 32'(dn_data_out), 32'(NOP));

      // rdy_in low under traffic
      cyc(1'b1, 1'b0, 1'b1, 8'h07, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'h08, 1'b1);
         chk("frozen_data", 32'(dn_data_out), 32'h07);
         chk("frozen_valid", 32'(dn_valid_out), 32'd1);
         chk("frozen_up_ready", 32'(up_ready_out), 32'd0);
      end
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("unfreeze_drain", 32'(dn_data_out), 32'(NOP));

      // asynchronous reset between edges while holding 0x9
      cyc(1'b1, 1'b0, 1'b1, 8'h09, 1'b0);
      chk("prerst_data", 32'(dn_data_out), 32'h09);
      up_valid_in = 1'b0;
      dn_ready_in = 1'b1;
      #1 rst_in = 1'b1;
      #1;
      chk("midrst_dn_valid", 32'(dn_valid_out), 32'd0);
      chk("midrst_dn_data", 32'(dn_data_out), 32'(NOP));
      chk("midrst_bubble_cnt", 32'(bubble_cnt_out), 32'd0);
      rst_in = 1'b0;
      sb_q.delete();
      exp_cnt = '0;

      // empty for 2^CW+3 cycles: counter saturates
      for (int i = 1; i <= 19; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
         if (i == 5)
            chk("bubble_cnt_5", 32'(bubble_cnt_out), 32'd5);
      end
      chk("bubble_cnt_sat", 32'(bubble_cnt_out), 32'hF);
      cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
      chk("bubble_cnt_flush_keep", 32'(bubble_cnt_out), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
